// File: rtl/local_frc_to_remote_packer.sv
// Packs remote-destined force records into AXIS beats, NUM_SUB_PACKETS per beat, first record in the top slot.
// Partial batches close on a record's last flag or after FLUSH_TIMEOUT idle cycles; one beat can wait behind the output register.
module local_frc_to_remote_packer #(
  parameter int AXIS_TDATA_WIDTH     = 512,
  parameter int NUM_SUB_PACKETS      = 4,
  parameter int SUB_PACKET_WIDTH     = 128,
  parameter int FLOAT_WIDTH          = 32,
  parameter int GLOBAL_CELL_ID_WIDTH = 4,
  parameter int PARTICLE_ID_WIDTH    = 8,
  parameter int FLUSH_TIMEOUT        = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3*FLOAT_WIDTH-1:0]          i_frc,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0] i_gcid,
  input  logic [PARTICLE_ID_WIDTH-1:0]      i_parid,
  input  logic                              i_last,
  input  logic                              i_frc_valid,
  output logic                              o_frc_ready,
  output logic [AXIS_TDATA_WIDTH-1:0]       o_tdata,
  output logic                              o_tvalid,
  output logic                              o_tlast,
  input  logic                              i_tready
);

  localparam int SW        = SUB_PACKET_WIDTH;
  localparam int GW3       = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int LAST_BIT  = 3 * FLOAT_WIDTH;
  localparam int GCID_LSB  = LAST_BIT + 1;
  localparam int PARID_LSB = GCID_LSB + GW3;
  localparam int CNT_W     = (NUM_SUB_PACKETS > 1) ? $clog2(NUM_SUB_PACKETS) : 1;
  localparam int IDLE_W    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam bit TO_EN     = (FLUSH_TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_SUB_PACKETS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = (FLUSH_TIMEOUT > 0) ? IDLE_W'(FLUSH_TIMEOUT - 1) : '0;

  logic [AXIS_TDATA_WIDTH-1:0] pack_q, pack_d;
  logic [AXIS_TDATA_WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0]            slot_cntr_q, slot_cntr_d;
  logic [IDLE_W-1:0]           idle_cntr_q, idle_cntr_d;
  logic                        pack_full_q, pack_full_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;

  logic [SW-1:0]              rec_slot;
  logic [NUM_SUB_PACKETS-1:0] wr_en;
  logic [NUM_SUB_PACKETS-1:0] slot_last;
  logic                       out_free, accept, xfer, idle_tick, timeout;

  assign out_free    = ~tvalid_q | i_tready;
  assign o_frc_ready = rst_n & (~pack_full_q | out_free);
  assign accept      = i_frc_valid & o_frc_ready;
  assign xfer        = pack_full_q & out_free;
  // A non-empty slot counter implies the pack is still open, so it alone marks a partial batch.
  assign idle_tick   = (slot_cntr_q != '0) & ~pack_full_q & ~accept;
  assign timeout     = TO_EN & idle_tick & (idle_cntr_q == IDLE_MAX);

  always_comb begin
    rec_slot                        = '0;
    rec_slot[LAST_BIT-1:0]          = i_frc;
    rec_slot[LAST_BIT]              = i_last;
    rec_slot[GCID_LSB +: GW3]       = i_gcid;
    rec_slot[PARID_LSB +: PARTICLE_ID_WIDTH] = i_parid;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SUB_PACKETS; gi++) begin : g_slot
      assign wr_en[gi]     = accept & (slot_cntr_q == CNT_W'(NUM_SUB_PACKETS - 1 - gi));
      assign slot_last[gi] = pack_q[gi*SW + LAST_BIT];
      // The incoming write wins over the clear that accompanies a transfer.
      assign pack_d[gi*SW +: SW] = wr_en[gi] ? rec_slot :
                                   (xfer ? '0 : pack_q[gi*SW +: SW]);
    end
  endgenerate

  always_comb begin
    slot_cntr_d = slot_cntr_q;
    pack_full_d = pack_full_q;
    idle_cntr_d = '0;
    out_d       = out_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    if (xfer) pack_full_d = 1'b0;

    if (accept) begin
      if (slot_cntr_q == LAST_SLOT || i_last) begin
        slot_cntr_d = '0;
        pack_full_d = 1'b1;
      end else begin
        slot_cntr_d = slot_cntr_q + CNT_W'(1);
      end
    end else if (idle_tick) begin
      if (timeout) begin
        slot_cntr_d = '0;
        pack_full_d = 1'b1;
      end else begin
        idle_cntr_d = idle_cntr_q + IDLE_W'(1);
      end
    end

    if (xfer) begin
      out_d    = pack_q;
      tvalid_d = 1'b1;
      tlast_d  = |slot_last;
    end else if (tvalid_q & i_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q      <= '0;
      out_q       <= '0;
      slot_cntr_q <= '0;
      idle_cntr_q <= '0;
      pack_full_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      out_q       <= out_d;
      slot_cntr_q <= slot_cntr_d;
      idle_cntr_q <= idle_cntr_d;
      pack_full_q <= pack_full_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  assign o_tdata  = out_q;
  assign o_tvalid = tvalid_q;
  assign o_tlast  = tlast_q;

endmodule

// File: tb/tb_local_frc_to_remote_packer.sv
// Bench for local_frc_to_remote_packer: directed scenarios plus a random stream scored
// against a batch-level reference model (records grouped by count, last flag and idle timeout).
module tb_local_frc_to_remote_packer;

  localparam int SW = 128;
  localparam int NS = 4;
  localparam int DW = 512;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [95:0]   i_frc;
  logic [11:0]   i_gcid;
  logic [7:0]    i_parid;
  logic          i_last, i_frc_valid, o_frc_ready;
  logic [DW-1:0] o_tdata;
  logic          o_tvalid, o_tlast, i_tready;

  logic [95:0]   z_frc;
  logic [11:0]   z_gcid;
  logic [7:0]    z_parid;
  logic          z_last, z_valid, z_ready;
  logic [DW-1:0] z_tdata;
  logic          z_tvalid, z_tlast, z_tready;

  always #5 clk = ~clk;

  local_frc_to_remote_packer #(.FLUSH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_frc(i_frc), .i_gcid(i_gcid), .i_parid(i_parid),
    .i_last(i_last), .i_frc_valid(i_frc_valid), .o_frc_ready(o_frc_ready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .i_tready(i_tready)
  );

  local_frc_to_remote_packer #(.FLUSH_TIMEOUT(0)) dut_noto (
    .clk(clk), .rst_n(rst_n), .i_frc(z_frc), .i_gcid(z_gcid), .i_parid(z_parid),
    .i_last(z_last), .i_frc_valid(z_valid), .o_frc_ready(z_ready),
    .o_tdata(z_tdata), .o_tvalid(z_tvalid), .o_tlast(z_tlast), .i_tready(z_tready)
  );

  int total = 0;
  int bad = 0;
  int beats_out = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the current open batch and the beats it has produced.
  typedef logic [SW-1:0] slot_t;
  slot_t         batch[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  int            idle_cnt = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  function automatic slot_t mk_slot(input logic [95:0] frc, input logic [11:0] gcid,
                                    input logic [7:0] parid, input logic last);
    slot_t s = '0;
    s[31:0]    = frc[31:0];
    s[63:32]   = frc[63:32];
    s[95:64]   = frc[95:64];
    s[96]      = last;
    s[108:97]  = gcid;
    s[116:109] = parid;
    return s;
  endfunction

  task automatic close_batch();
    logic [DW-1:0] b = '0;
    logic l = 1'b0;
    foreach (batch[k]) begin
      b[(NS-1-k)*SW +: SW] = batch[k];
      l = l | batch[k][96];
    end
    exp_data.push_back(b);
    exp_last.push_back(l);
    batch.delete();
    idle_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      batch.delete();
      exp_data.delete();
      exp_last.delete();
      idle_cnt = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_val("hold_valid", o_tvalid, 1);
        check_val("hold_data", o_tdata, prev_data);
        check_val("hold_last", o_tlast, prev_last);
      end
      if (o_tvalid && i_tready) begin
        beats_out++;
        if (exp_data.size() == 0) check_val("extra_beat", o_tvalid, 0);
        else begin
          check_val("beat_data", o_tdata, exp_data.pop_front());
          check_val("beat_last", o_tlast, exp_last.pop_front());
        end
      end
      if (i_frc_valid && o_frc_ready) begin
        batch.push_back(mk_slot(i_frc, i_gcid, i_parid, i_last));
        idle_cnt = 0;
        if (batch.size() == NS || i_last) close_batch();
      end else if (batch.size() != 0) begin
        idle_cnt++;
        if (idle_cnt == TO) close_batch();
      end
      hold_prev = o_tvalid && !i_tready;
      prev_data = o_tdata;
      prev_last = o_tlast;
    end
  end

  // Presents one record and returns once it has been accepted.
  task automatic send_rec(input logic [95:0] frc, input logic [7:0] parid,
                          input logic last, output int waits);
    logic ok;
    waits = 0;
    ok = 1'b0;
    i_frc = frc;
    i_gcid = 12'($urandom);
    i_parid = parid;
    i_last = last;
    i_frc_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = o_frc_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        waits++;
        if (waits > 500) begin
          check_val("send_stuck", o_frc_ready, 1);
          ok = 1'b1;
        end
      end
    end
    i_frc_valid = 1'b0;
  endtask

  task automatic send_rnd(input logic [7:0] parid, input logic last, output int waits);
    send_rec({$urandom, $urandom, $urandom}, parid, last, waits);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_data.size() != 0 || batch.size() != 0 || o_tvalid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain", exp_data.size() + batch.size(), 0);
  endtask

  logic [DW-1:0] tmp;
  int w, stalls, b0, n, zero_beats;
  logic z_ok;
  logic rand_done = 1'b0;

  initial begin
    #500_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    i_frc = '0; i_gcid = '0; i_parid = '0; i_last = 1'b0; i_frc_valid = 1'b0; i_tready = 1'b1;
    z_frc = '0; z_gcid = '0; z_parid = '0; z_last = 1'b0; z_valid = 1'b0; z_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", o_tvalid, 0);
    check_val("rst_tdata", o_tdata, 0);
    check_val("rst_tlast", o_tlast, 0);
    check_val("rst_ready", o_frc_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("ready_after_rst", o_frc_ready, 1);

    // 1) four back-to-back records, beat two cycles after the fourth
    for (int p = 1; p <= 4; p++) send_rnd(8'(p), 1'b0, w);
    check_val("t1_lat_n1", o_tvalid, 0);
    @(posedge clk);
    #1;
    tmp = o_tdata;
    check_val("t1_lat_n2", o_tvalid, 1);
    check_val("t1_slot3_parid", tmp[3*SW+109 +: 8], 1);
    check_val("t1_slot0_parid", tmp[109 +: 8], 4);
    check_val("t1_tlast", o_tlast, 0);
    repeat (3) @(posedge clk);
    #1;

    // 2) two records, second carries last
    send_rnd(8'd5, 1'b0, w);
    send_rec({$urandom, $urandom, 32'h3F800000}, 8'd6, 1'b1, w);
    @(posedge clk);
    #1;
    tmp = o_tdata;
    check_val("t2_tvalid", o_tvalid, 1);
    check_val("t2_tlast", o_tlast, 1);
    check_val("t2_slot2_last", tmp[2*SW+96], 1);
    check_val("t2_slot2_x", tmp[2*SW +: 32], 32'h3F800000);
    check_val("t2_pad_zero", tmp[2*SW-1:0], 0);
    repeat (3) @(posedge clk);
    #1;

    // 3) lone record flushed by the idle timeout; never with a zero timeout
    send_rnd(8'd7, 1'b0, w);
    n = 1;
    while (!o_tvalid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    tmp = o_tdata;
    check_val("t3_timeout_lat", n, TO + 2);
    check_val("t3_parid", tmp[3*SW+109 +: 8], 7);
    check_val("t3_pad_zero", tmp[3*SW-1:0], 0);
    z_frc = {$urandom, $urandom, $urandom};
    z_parid = 8'd9;
    z_valid = 1'b1;
    @(negedge clk);
    z_ok = z_ready;
    @(posedge clk);
    #1;
    z_valid = 1'b0;
    check_val("t3_z_accept", z_ok, 1);
    zero_beats = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (z_tvalid) zero_beats++;
    end
    check_val("t3_no_timeout", zero_beats, 0);

    // 4) backpressure: ready drops after eight accepts, nothing lost
    b0 = beats_out;
    i_tready = 1'b0;
    stalls = 0;
    for (int p = 0; p < 8; p++) begin
      send_rnd(8'(16 + p), 1'b0, w);
      stalls += w;
    end
    check_val("t4_no_stall", stalls, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("t4_ready_low", o_frc_ready, 0);
      @(posedge clk);
      #1;
    end
    i_tready = 1'b1;
    for (int p = 8; p < 12; p++) send_rnd(8'(16 + p), 1'b0, w);
    wait_drain();
    check_val("t4_beats", beats_out - b0, 3);

    // 5) sixteen continuous records
    b0 = beats_out;
    stalls = 0;
    for (int p = 0; p < 16; p++) begin
      send_rnd(8'(32 + p), 1'b0, w);
      stalls += w;
    end
    check_val("t5_no_stall", stalls, 0);
    wait_drain();
    check_val("t5_beats", beats_out - b0, 4);

    // 6) reset with a beat held and a partial batch open
    i_tready = 1'b0;
    for (int p = 0; p < 7; p++) send_rnd(8'(64 + p), 1'b0, w);
    check_val("t6_pre_valid", o_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_tvalid", o_tvalid, 0);
    check_val("t6_tdata", o_tdata, 0);
    check_val("t6_tlast", o_tlast, 0);
    check_val("t6_ready", o_frc_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_tready = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) send_rnd(8'(40 + p), 1'b0, w);
    @(posedge clk);
    #1;
    tmp = o_tdata;
    check_val("t6_clean_valid", o_tvalid, 1);
    check_val("t6_slot3_parid", tmp[3*SW+109 +: 8], 40);
    check_val("t6_slot0_parid", tmp[109 +: 8], 43);
    wait_drain();

    // random stream with random backpressure, gaps and last flags
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) i_tready = ($urandom_range(3) != 0);
        end
      end
    join_none
    for (int r = 0; r < 300; r++) begin
      n = ($urandom_range(9) == 0) ? 12 : $urandom_range(2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
      send_rnd(8'($urandom), ($urandom_range(7) == 0), w);
    end
    rand_done = 1'b1;
    @(posedge clk);
    #2;
    i_tready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
